// File: rtl/serdes_pkg.sv
// Shared SERDES alignment package: window-select FSM states and mask geometry
// constants, also used by the lock-mask generator.
package serdes_pkg;

    localparam int SERDES_TAP_NUM = 32;
    localparam int SERDES_MASK_AW = 4;
    localparam int SERDES_TAP_AW  = $clog2(SERDES_TAP_NUM);
    localparam int SERDES_LEN_W   = SERDES_TAP_AW + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_SCAN,
        ST_CLOSE,
        ST_NEXT,
        ST_DECIDE,
        ST_DONE
    } WinFsm_e;

    // Centre of a run: start + floor((len-1)/2), in 8-bit arithmetic.
    function automatic logic [7:0] win_centre(input logic [SERDES_TAP_AW-1:0] start,
                                              input logic [SERDES_LEN_W-1:0]  len);
        logic [7:0] half;
        half = (8'(len) - 8'd1) >> 1;
        return 8'(start) + half;
    endfunction

endpackage

// File: rtl/serdes_run_tracker.sv
// Serial run tracker: follows the current run of 1s in a tap mask fed one
// bit per cycle and flags when a non-empty run ends.
module serdes_run_tracker
    import serdes_pkg::*;
(
    input  logic                     px_clk,
    input  logic                     px_reset_n,
    input  logic                     clear,
    input  logic                     shift_en,
    input  logic                     bit_in,
    input  logic [SERDES_TAP_AW-1:0] tap_idx,
    input  logic                     flush,
    output logic [SERDES_LEN_W-1:0]  run_len,
    output logic [SERDES_TAP_AW-1:0] run_start,
    output logic                     close_stb
);

    // A run closes on a 0 bit or on the end-of-mask flush; run_len/run_start
    // still hold the closing run's values during the strobe.
    always_comb begin
        close_stb = (run_len != '0) && ((shift_en && !bit_in) || flush);
    end

    // Extend, start or terminate the current run.
    always_ff @(posedge px_clk or negedge px_reset_n) begin
        if (!px_reset_n) begin
            run_len   <= '0;
            run_start <= '0;
        end else if (clear) begin
            run_len   <= '0;
            run_start <= '0;
        end else if (shift_en) begin
            if (bit_in) begin
                run_len <= run_len + 1'b1;
                if (run_len == '0) begin
                    run_start <= tap_idx;
                end
            end else begin
                run_len <= '0;
            end
        end else if (flush) begin
            run_len <= '0;
        end
    end

endmodule

// File: rtl/serdes_lock_window_select.sv
// Lock-window selector: reads SLIP_NUM lock masks, finds the widest run of
// locked taps over all slips and publishes slip, centre tap and verdict.
// Optional macro SERDES_SEL_HOLD_EN: on fail, delay/slip keep the last pass.
module serdes_lock_window_select
    import serdes_pkg::*;
#(
    parameter int SLIP_NUM   = 12,
    parameter int MIN_WINDOW = 4
) (
    input  logic                      px_clk,
    input  logic                      px_reset_n,
    input  logic                      start,
    output logic [SERDES_MASK_AW-1:0] lock_mask_raddr_out,
    output logic                      lock_mask_re_out,
    input  logic [SERDES_TAP_NUM-1:0] lock_mask_din,
    output logic [7:0]                delay_sel_out,
    output logic [7:0]                slip_sel_out,
    output logic [7:0]                window_len_out,
    output logic                      valid_out,
    output logic                      fail_out,
    output logic                      busy_out,
    output logic                      done_out
);

    WinFsm_e                   state, state_nxt;
    logic [SERDES_MASK_AW-1:0] scnt;
    logic [SERDES_TAP_AW-1:0]  tcnt;
    logic [SERDES_TAP_NUM-1:0] mask;
    logic [SERDES_LEN_W-1:0]   best_len;
    logic [SERDES_TAP_AW-1:0]  best_start;
    logic [SERDES_MASK_AW-1:0] best_slip;
    logic [SERDES_LEN_W-1:0]   run_len;
    logic [SERDES_TAP_AW-1:0]  run_start;
    logic                      close_stb;
    logic                      last_slip;
    logic                      pass;
    logic [7:0]                centre;

    assign last_slip = ({1'b0, scnt} + 5'd1) == 5'(SLIP_NUM);
    assign pass      = int'(best_len) >= MIN_WINDOW;
    assign centre    = win_centre(best_start, best_len);

    serdes_run_tracker u_run (
        .px_clk     (px_clk),
        .px_reset_n (px_reset_n),
        .clear      (state == ST_WAIT),
        .shift_en   (state == ST_SCAN),
        .bit_in     (mask[tcnt]),
        .tap_idx    (tcnt),
        .flush      (state == ST_CLOSE),
        .run_len    (run_len),
        .run_start  (run_start),
        .close_stb  (close_stb)
    );

    // FSM state register.
    always_ff @(posedge px_clk or negedge px_reset_n) begin
        if (!px_reset_n) state <= ST_IDLE;
        else             state <= state_nxt;
    end

    // Next-state logic and state-decoded control outputs.
    always_comb begin
        state_nxt           = state;
        lock_mask_re_out    = 1'b0;
        lock_mask_raddr_out = '0;
        busy_out            = (state != ST_IDLE);
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_READ;
            ST_READ: begin
                lock_mask_re_out    = 1'b1;
                lock_mask_raddr_out = scnt;
                state_nxt           = ST_WAIT;
            end
            ST_WAIT:   state_nxt = ST_SCAN;
            ST_SCAN:   if (tcnt == SERDES_TAP_AW'(SERDES_TAP_NUM - 1)) state_nxt = ST_CLOSE;
            ST_CLOSE:  state_nxt = ST_NEXT;
            ST_NEXT:   state_nxt = last_slip ? ST_DECIDE : ST_READ;
            ST_DECIDE: state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Slip/tap counters and best-run bookkeeping; strict '>' keeps the
    // earliest slip and lowest tap on ties.
    always_ff @(posedge px_clk or negedge px_reset_n) begin
        if (!px_reset_n) begin
            scnt       <= '0;
            tcnt       <= '0;
            best_len   <= '0;
            best_start <= '0;
            best_slip  <= '0;
        end else begin
            if (state == ST_IDLE && start) begin
                scnt       <= '0;
                best_len   <= '0;
                best_start <= '0;
                best_slip  <= '0;
            end else if (close_stb && (run_len > best_len)) begin
                best_len   <= run_len;
                best_start <= run_start;
                best_slip  <= scnt;
            end
            if (state == ST_WAIT) tcnt <= '0;
            if (state == ST_SCAN) tcnt <= tcnt + 1'b1;
            if (state == ST_NEXT) scnt <= scnt + 1'b1;
        end
    end

    // Mask capture one cycle after the RAM read.
    always_ff @(posedge px_clk) begin
        if (state == ST_WAIT) mask <= lock_mask_din;
    end

    // Result publication: registered on leaving ST_DECIDE so it is visible
    // together with done_out.
    always_ff @(posedge px_clk or negedge px_reset_n) begin
        if (!px_reset_n) begin
            done_out       <= 1'b0;
            valid_out      <= 1'b0;
            fail_out       <= 1'b0;
            window_len_out <= '0;
            delay_sel_out  <= '0;
            slip_sel_out   <= '0;
        end else begin
            done_out <= (state == ST_DECIDE);
            if (state == ST_DECIDE) begin
                window_len_out <= 8'(best_len);
                valid_out      <= pass;
                fail_out       <= !pass;
                if (pass) begin
                    delay_sel_out <= centre;
                    slip_sel_out  <= 8'(best_slip);
                end else begin
`ifdef SERDES_SEL_HOLD_EN
                    delay_sel_out <= delay_sel_out;
                    slip_sel_out  <= slip_sel_out;
`else
                    delay_sel_out <= '0;
                    slip_sel_out  <= '0;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_serdes_lock_window_select.sv
// Self-checking bench for serdes_lock_window_select: directed and random mask
// tables scored against a run-search reference model.
module tb_serdes_lock_window_select;

    localparam int SLIP_NUM   = 12;
    localparam int MIN_WINDOW = 4;
    localparam int DONE_CYC   = SLIP_NUM * 36 + 2;

    logic        px_clk = 1'b0;
    logic        px_reset_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  lock_mask_raddr_out;
    logic        lock_mask_re_out;
    logic [31:0] lock_mask_din = '0;
    logic [7:0]  delay_sel_out, slip_sel_out, window_len_out;
    logic        valid_out, fail_out, busy_out, done_out;

    logic [31:0] masks [16];
    int checks = 0;
    int errors = 0;

    // expected result and hold state of the reference model
    int e_len, e_delay, e_slip;
    bit e_valid;
    int hold_delay = 0;
    int hold_slip  = 0;

    serdes_lock_window_select #(.SLIP_NUM(SLIP_NUM), .MIN_WINDOW(MIN_WINDOW)) dut (
        .px_clk              (px_clk),
        .px_reset_n          (px_reset_n),
        .start               (start),
        .lock_mask_raddr_out (lock_mask_raddr_out),
        .lock_mask_re_out    (lock_mask_re_out),
        .lock_mask_din       (lock_mask_din),
        .delay_sel_out       (delay_sel_out),
        .slip_sel_out        (slip_sel_out),
        .window_len_out      (window_len_out),
        .valid_out           (valid_out),
        .fail_out            (fail_out),
        .busy_out            (busy_out),
        .done_out            (done_out)
    );

    always #5 px_clk = ~px_clk;

    // Lock-mask RAM: data appears one cycle after the read enable.
    always @(posedge px_clk) begin
        if (lock_mask_re_out) lock_mask_din <= masks[lock_mask_raddr_out];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: enumerate every maximal run (a 1 whose left neighbour is 0),
    // keep the first strictly-longest one in slip/tap order.
    task automatic model_eval();
        int bl, bs, bsl;
        bl = 0; bs = 0; bsl = 0;
        for (int s = 0; s < SLIP_NUM; s++) begin
            for (int d = 0; d < 32; d++) begin
                if (masks[s][d] && (d == 0 || !masks[s][d-1])) begin
                    int l;
                    l = 0;
                    while (d + l < 32 && masks[s][d+l]) l++;
                    if (l > bl) begin bl = l; bs = d; bsl = s; end
                end
            end
        end
        e_len   = bl;
        e_valid = (bl >= MIN_WINDOW);
        if (e_valid) begin
            e_delay = bs + (bl - 1) / 2;
            e_slip  = bsl;
            hold_delay = e_delay;
            hold_slip  = e_slip;
        end else begin
`ifdef SERDES_SEL_HOLD_EN
            e_delay = hold_delay;
            e_slip  = hold_slip;
`else
            e_delay = 0;
            e_slip  = 0;
`endif
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"},  busy_out, 0);
        chk({tag, "_done"},  done_out, 0);
        chk({tag, "_re"},    lock_mask_re_out, 0);
        chk({tag, "_raddr"}, lock_mask_raddr_out, 0);
        chk({tag, "_valid"}, valid_out, 0);
        chk({tag, "_fail"},  fail_out, 0);
        chk({tag, "_len"},   window_len_out, 0);
        chk({tag, "_delay"}, delay_sel_out, 0);
        chk({tag, "_slip"},  slip_sel_out, 0);
    endtask

    // One full selection run with cycle-accurate checks; inject_at > 0 pulses
    // a stray start while busy.
    task automatic run_and_check(input int inject_at);
        model_eval();
        @(negedge px_clk); start = 1'b1;
        @(posedge px_clk); #1 start = 1'b0;
        for (int c = 1; c <= DONE_CYC + 2; c++) begin
            bit exp_re;
            @(negedge px_clk);
            if (inject_at > 0 && c == inject_at)     start = 1'b1;
            if (inject_at > 0 && c == inject_at + 1) start = 1'b0;
            exp_re = (c >= 1) && ((c - 1) % 36 == 0) && ((c - 1) / 36 < SLIP_NUM);
            chk("busy", busy_out, (c <= DONE_CYC));
            chk("done", done_out, (c == DONE_CYC));
            chk("re",   lock_mask_re_out, exp_re);
            if (exp_re) chk("raddr", lock_mask_raddr_out, (c - 1) / 36);
            if (c >= DONE_CYC) begin
                chk("len",   window_len_out, e_len);
                chk("valid", valid_out, e_valid);
                chk("fail",  fail_out, !e_valid);
                chk("delay", delay_sel_out, e_delay);
                chk("slip",  slip_sel_out, e_slip);
            end
        end
    endtask

    function automatic logic [31:0] rand_mask();
        logic [63:0] m;
        int len, st;
        case ($urandom_range(0, 4))
            0: return 32'h0;
            1: return $urandom;
            2: begin
                len = $urandom_range(1, 32);
                st  = $urandom_range(0, 32 - len);
                m   = ((64'd1 << len) - 64'd1) << st;
                return m[31:0];
            end
            3: return $urandom & $urandom & $urandom;
            default: return ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom | $urandom;
        endcase
    endfunction

    task automatic clear_masks();
        for (int i = 0; i < 16; i++) masks[i] = '0;
    endtask

    initial begin
        clear_masks();
        repeat (3) @(posedge px_clk);
        #1 check_all_zero("rst");
        @(negedge px_clk) px_reset_n = 1'b1;
        repeat (2) @(posedge px_clk);

        // all masks zero: fail, len 0
        run_and_check(0);
        chk("t1_fail", fail_out, 1);
        chk("t1_len", window_len_out, 0);
        chk("t1_delay", delay_sel_out, 0);
        chk("t1_slip", slip_sel_out, 0);

        // single window on slip 5
        clear_masks(); masks[5] = 32'h0000_FF00;
        run_and_check(0);
        chk("t2_slip", slip_sel_out, 5);
        chk("t2_len", window_len_out, 8);
        chk("t2_delay", delay_sel_out, 11);
        chk("t2_valid", valid_out, 1);

        // tie between slip 2 and 7
        clear_masks(); masks[2] = 32'h0003_F000; masks[7] = 32'h0003_F000;
        run_and_check(0);
        chk("t3_slip", slip_sel_out, 2);
        chk("t3_len", window_len_out, 6);
        chk("t3_delay", delay_sel_out, 14);

        // run reaching bit 31, with a stray start while busy
        clear_masks(); masks[0] = 32'hFF00_000F;
        run_and_check(60);
        chk("t4_slip", slip_sel_out, 0);
        chk("t4_len", window_len_out, 8);
        chk("t4_delay", delay_sel_out, 27);

        // short run only: fail
        clear_masks(); masks[3] = 32'h0000_0007;
        run_and_check(0);
        chk("t5_len", window_len_out, 3);
        chk("t5_fail", fail_out, 1);
        chk("t5_valid", valid_out, 0);
`ifdef SERDES_SEL_HOLD_EN
        chk("t5_delay", delay_sel_out, 27);
`else
        chk("t5_delay", delay_sel_out, 0);
`endif
        chk("t5_slip", slip_sel_out, 0);

        // reset mid-run, then a clean run
        clear_masks(); masks[5] = 32'h0000_FF00;
        @(negedge px_clk); start = 1'b1;
        @(posedge px_clk); #1 start = 1'b0;
        repeat (99) @(posedge px_clk);
        @(negedge px_clk) px_reset_n = 1'b0;
        #1 check_all_zero("abort");
        hold_delay = 0; hold_slip = 0;
        repeat (2) @(posedge px_clk);
        #1 check_all_zero("abort_hold");
        @(negedge px_clk) px_reset_n = 1'b1;
        run_and_check(0);
        chk("t6_delay", delay_sel_out, 11);
        chk("t6_slip", slip_sel_out, 5);

        // randomized tables
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 16; i++) masks[i] = rand_mask();
            run_and_check((r % 2 == 1) ? int'($urandom_range(2, 400)) : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
